// File: rtl/stream_frame_gate.sv
// Gates whole sensor frames on the AND of stream enable, acquisition start and
// encryption state, with a fixed two-cycle latency and passed/dropped frame counters.
module stream_frame_gate #(
    parameter int SENSOR_DAT_WIDTH = 10,
    parameter int CHANNEL_NUM      = 4,
    parameter int CNT_WD           = 16
) (
    input  logic                                      clk_pix,
    input  logic                                      reset_pix,
    input  logic                                      i_fval,
    input  logic                                      i_lval,
    input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0]   iv_pix_data,
    input  logic                                      i_stream_enable,
    input  logic                                      i_acquisition_start,
    input  logic                                      i_encrypt_state,
    output logic                                      o_fval,
    output logic                                      o_lval,
    output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0]   ov_pix_data,
    output logic                                      o_frame_done,
    output logic [CNT_WD-1:0]                         ov_frame_cnt,
    output logic [CNT_WD-1:0]                         ov_drop_cnt
);

    localparam int                 DAT_WD   = SENSOR_DAT_WIDTH * CHANNEL_NUM;
    localparam logic [CNT_WD-1:0]  CNT_ONE  = {{(CNT_WD-1){1'b0}}, 1'b1};
    localparam logic [CNT_WD-1:0]  CNT_ZERO = {CNT_WD{1'b0}};
    localparam logic [DAT_WD-1:0]  DAT_ZERO = {DAT_WD{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t              state_r;
    logic                fval_prev_r;
    logic                rise_s;
    logic                fall_s;
    logic                enable_s;
    logic                pass_s;
    logic                done_s;
    logic                drop_s;

    logic                pass_d1_r;
    logic                lval_d1_r;
    logic [DAT_WD-1:0]   data_d1_r;
    logic                done_d1_r;
    logic                drop_d1_r;

    // Edge detection and per-cycle gate decision; the rising-edge cycle itself
    // is admitted so the output frame starts with its first input cycle.
    always_comb begin
        rise_s   = i_fval & ~fval_prev_r;
        fall_s   = ~i_fval & fval_prev_r;
        enable_s = i_stream_enable & i_acquisition_start & i_encrypt_state;
        pass_s   = 1'b0;
        done_s   = 1'b0;
        drop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s && enable_s) begin
                    pass_s = 1'b1;
                end else begin
                    pass_s = 1'b0;
                end
            end
            PASS: begin
                pass_s = i_fval;
                done_s = fall_s;
            end
            DROP: begin
                drop_s = fall_s;
            end
            default: begin
                pass_s = 1'b0;
                done_s = 1'b0;
                drop_s = 1'b0;
            end
        endcase
    end

    // Frame gate FSM: the pass/drop decision is latched at the rising edge only.
    always_ff @(posedge clk_pix) begin
        if (reset_pix) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rise_s) begin
                        state_r <= enable_s ? PASS : DROP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PASS, DROP: begin
                    if (fall_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // First pipeline stage; previous-fval resets high so a frame already in
    // flight at reset release never looks like a new frame.
    always_ff @(posedge clk_pix) begin
        if (reset_pix) begin
            fval_prev_r <= 1'b1;
            pass_d1_r   <= 1'b0;
            lval_d1_r   <= 1'b0;
            data_d1_r   <= DAT_ZERO;
            done_d1_r   <= 1'b0;
            drop_d1_r   <= 1'b0;
        end else begin
            fval_prev_r <= i_fval;
            pass_d1_r   <= pass_s;
            lval_d1_r   <= i_lval;
            data_d1_r   <= iv_pix_data;
            done_d1_r   <= done_s;
            drop_d1_r   <= drop_s;
        end
    end

    // Output stage: masked stream, done pulse and wrapping frame statistics.
    always_ff @(posedge clk_pix) begin
        if (reset_pix) begin
            o_fval       <= 1'b0;
            o_lval       <= 1'b0;
            ov_pix_data  <= DAT_ZERO;
            o_frame_done <= 1'b0;
            ov_frame_cnt <= CNT_ZERO;
            ov_drop_cnt  <= CNT_ZERO;
        end else begin
            o_fval       <= pass_d1_r;
            o_lval       <= pass_d1_r & lval_d1_r;
            ov_pix_data  <= (pass_d1_r && lval_d1_r) ? data_d1_r : DAT_ZERO;
            o_frame_done <= done_d1_r;
            ov_frame_cnt <= done_d1_r ? (ov_frame_cnt + CNT_ONE) : ov_frame_cnt;
            ov_drop_cnt  <= drop_d1_r ? (ov_drop_cnt + CNT_ONE) : ov_drop_cnt;
        end
    end

endmodule

// File: tb/tb_stream_frame_gate.sv
// Directed bench for stream_frame_gate: hand-labelled frames drive a two-cycle
// expectation pipeline; a narrow-counter instance exercises counter wrap.
module tb_stream_frame_gate;

    localparam int DW = 40;
    localparam logic [1:0] M_NONE = 2'd0;
    localparam logic [1:0] M_PASS = 2'd1;
    localparam logic [1:0] M_DROP = 2'd2;

    typedef struct packed {
        logic          fv;
        logic          lv;
        logic [DW-1:0] data;
        logic          done;
        logic [15:0]   fc;
        logic [15:0]   dc;
    } exp_t;

    logic          clk_pix = 1'b0;
    logic          reset_pix;
    logic          i_fval, i_lval;
    logic [DW-1:0] iv_pix_data;
    logic          i_stream_enable, i_acquisition_start, i_encrypt_state;
    logic          o_fval, o_lval, o_frame_done;
    logic [DW-1:0] ov_pix_data;
    logic [15:0]   ov_frame_cnt, ov_drop_cnt;
    logic          sm_fval, sm_lval, sm_frame_done;
    logic [DW-1:0] sm_pix_data;
    logic [2:0]    sm_frame_cnt, sm_drop_cnt;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            n_cyc   = 0;
    int            seen_done = 0;
    exp_t          e1, e2, en;
    logic [15:0]   cur_f, cur_d, seq;
    logic          prev_fv;
    logic [1:0]    prev_mode;

    always #5 clk_pix = ~clk_pix;

    stream_frame_gate #(.SENSOR_DAT_WIDTH(10), .CHANNEL_NUM(4), .CNT_WD(16)) dut (
        .clk_pix(clk_pix), .reset_pix(reset_pix), .i_fval(i_fval), .i_lval(i_lval),
        .iv_pix_data(iv_pix_data), .i_stream_enable(i_stream_enable),
        .i_acquisition_start(i_acquisition_start), .i_encrypt_state(i_encrypt_state),
        .o_fval(o_fval), .o_lval(o_lval), .ov_pix_data(ov_pix_data),
        .o_frame_done(o_frame_done), .ov_frame_cnt(ov_frame_cnt), .ov_drop_cnt(ov_drop_cnt)
    );

    stream_frame_gate #(.SENSOR_DAT_WIDTH(10), .CHANNEL_NUM(4), .CNT_WD(3)) small_dut (
        .clk_pix(clk_pix), .reset_pix(reset_pix), .i_fval(i_fval), .i_lval(i_lval),
        .iv_pix_data(iv_pix_data), .i_stream_enable(i_stream_enable),
        .i_acquisition_start(i_acquisition_start), .i_encrypt_state(i_encrypt_state),
        .o_fval(sm_fval), .o_lval(sm_lval), .ov_pix_data(sm_pix_data),
        .o_frame_done(sm_frame_done), .ov_frame_cnt(sm_frame_cnt), .ov_drop_cnt(sm_drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed 0x%0h expected 0x%0h", tag, n_cyc, obs, exp);
        end
    endtask

    // One clock: check outputs against the expectation from two cycles ago,
    // then derive this cycle's expectation from the hand-assigned frame mode.
    task automatic cyc(input logic fv, input logic lv, input logic [1:0] mode, input logic rst);
        logic [DW-1:0] pix;
        logic          fall;
        if (n_cyc >= 2) begin
            chk("o_fval", o_fval, e2.fv);
            chk("o_lval", o_lval, e2.lv);
            chk("ov_pix_data", ov_pix_data, e2.data);
            chk("o_frame_done", o_frame_done, e2.done);
            chk("ov_frame_cnt", ov_frame_cnt, e2.fc);
            chk("ov_drop_cnt", ov_drop_cnt, e2.dc);
            chk("small_frame_cnt", sm_frame_cnt, e2.fc[2:0]);
            chk("small_drop_cnt", sm_drop_cnt, e2.dc[2:0]);
        end
        if (o_frame_done === 1'b1) seen_done++;
        pix = {seq[7:0], ~seq[7:0], seq ^ 16'h5A3C, seq[15:8]};
        if (rst) begin
            cur_f     = 16'd0;
            cur_d     = 16'd0;
            prev_fv   = 1'b1;
            prev_mode = M_NONE;
            e1        = '0;
            en        = '0;
        end else begin
            fall    = !fv && prev_fv;
            if (fall && prev_mode == M_PASS) cur_f = cur_f + 16'd1;
            if (fall && prev_mode == M_DROP) cur_d = cur_d + 16'd1;
            en.fv   = fv && (mode == M_PASS);
            en.lv   = en.fv && lv;
            en.data = en.lv ? pix : '0;
            en.done = fall && (prev_mode == M_PASS);
            en.fc   = cur_f;
            en.dc   = cur_d;
            prev_fv   = fv;
            prev_mode = mode;
        end
        e2 = e1;
        e1 = en;
        i_fval      = fv;
        i_lval      = lv;
        iv_pix_data = pix;
        reset_pix   = rst;
        seq         = seq + 16'd1;
        @(posedge clk_pix);
        @(negedge clk_pix);
        n_cyc++;
    endtask

    task automatic frame(input int lines, input int llen, input int hblank, input logic [1:0] mode,
                         input int vblank, input int se_at, input logic se_new);
        int k = 0;
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < llen; c++) begin
                if (k == se_at) i_stream_enable = se_new;
                cyc(1'b1, 1'b1, mode, 1'b0);
                k++;
            end
            for (int h = 0; h < hblank; h++) begin
                if (k == se_at) i_stream_enable = se_new;
                cyc(1'b1, 1'b0, mode, 1'b0);
                k++;
            end
        end
        for (int v = 0; v < vblank; v++) cyc(1'b0, 1'b0, mode, 1'b0);
    endtask

    initial begin
        int d0;
        e1 = '0; e2 = '0; en = '0;
        cur_f = 16'd0; cur_d = 16'd0; seq = 16'd0;
        prev_fv = 1'b1; prev_mode = M_NONE;
        i_stream_enable = 1'b1; i_acquisition_start = 1'b1; i_encrypt_state = 1'b1;
        i_fval = 1'b0; i_lval = 1'b0; iv_pix_data = '0; reset_pix = 1'b1;

        // Reset, then outputs must sit at zero
        repeat (3) cyc(1'b0, 1'b0, M_NONE, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, M_NONE, 1'b0);
        chk("reset_o_fval", o_fval, 1'b0);
        chk("reset_frame_cnt", ov_frame_cnt, 16'd0);

        // Basic pass: three frames with everything enabled
        repeat (3) frame(4, 8, 2, M_PASS, 4, -1, 1'b0);
        chk("basic_frame_cnt", ov_frame_cnt, 16'd3);
        chk("basic_drop_cnt", ov_drop_cnt, 16'd0);
        chk("basic_done_pulses", seen_done, 3);

        // SE toggled in vertical blanking
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, M_NONE, 1'b0);
            i_stream_enable = (i % 2 == 0) ? 1'b0 : 1'b1;
            cyc(1'b0, 1'b0, M_NONE, 1'b0);
            frame(2, 4, 1, (i % 2 == 0) ? M_DROP : M_PASS, 3 + i, -1, 1'b0);
        end
        chk("toggle_frame_cnt", ov_frame_cnt, 16'd6);
        chk("toggle_drop_cnt", ov_drop_cnt, 16'd3);

        // SE falls mid-frame (frame kept), rises mid-frame (frame still dropped)
        i_stream_enable = 1'b1;
        cyc(1'b0, 1'b0, M_NONE, 1'b0);
        frame(3, 4, 1, M_PASS, 3, 5, 1'b0);
        frame(3, 4, 1, M_DROP, 3, 5, 1'b1);
        frame(3, 4, 1, M_PASS, 3, -1, 1'b0);
        chk("midframe_frame_cnt", ov_frame_cnt, 16'd8);
        chk("midframe_drop_cnt", ov_drop_cnt, 16'd4);

        // Acquisition start and encryption state each gate on their own
        i_acquisition_start = 1'b0;
        frame(2, 3, 1, M_DROP, 3, -1, 1'b0);
        i_acquisition_start = 1'b1;
        i_encrypt_state = 1'b0;
        frame(2, 3, 1, M_DROP, 3, -1, 1'b0);
        i_encrypt_state = 1'b1;
        chk("gate_drop_cnt", ov_drop_cnt, 16'd6);

        // Enable changing exactly on the rising-edge cycle
        i_stream_enable = 1'b0;
        cyc(1'b0, 1'b0, M_NONE, 1'b0);
        frame(2, 3, 0, M_PASS, 3, 0, 1'b1);
        frame(2, 3, 0, M_DROP, 3, 0, 1'b0);
        i_stream_enable = 1'b1;
        chk("edge_frame_cnt", ov_frame_cnt, 16'd9);
        chk("edge_drop_cnt", ov_drop_cnt, 16'd7);

        // Minimum-size frames separated by a single low cycle
        d0 = seen_done;
        frame(1, 1, 0, M_PASS, 1, -1, 1'b0);
        frame(1, 2, 0, M_PASS, 1, -1, 1'b0);
        frame(1, 3, 0, M_PASS, 4, -1, 1'b0);
        chk("min_done_pulses", seen_done - d0, 3);
        chk("min_frame_cnt", ov_frame_cnt, 16'd12);

        // Line valid while frame valid is low never leaks out
        repeat (2) cyc(1'b0, 1'b1, M_PASS, 1'b0);
        cyc(1'b0, 1'b0, M_NONE, 1'b0);

        // Reset mid-frame: remainder suppressed, counters cleared
        repeat (4) cyc(1'b1, 1'b1, M_PASS, 1'b0);
        cyc(1'b1, 1'b1, M_NONE, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, M_NONE, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, M_NONE, 1'b0);
        chk("midreset_frame_cnt", ov_frame_cnt, 16'd0);
        chk("midreset_drop_cnt", ov_drop_cnt, 16'd0);

        // Reset released with frame valid high: that frame ignored, next passes
        repeat (2) cyc(1'b1, 1'b1, M_NONE, 1'b1);
        repeat (3) cyc(1'b1, 1'b1, M_NONE, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, M_NONE, 1'b0);
        d0 = seen_done;
        frame(2, 4, 1, M_PASS, 3, -1, 1'b0);
        chk("release_frame_cnt", ov_frame_cnt, 16'd1);
        chk("release_drop_cnt", ov_drop_cnt, 16'd0);
        chk("release_done_pulses", seen_done - d0, 1);

        // Counter wrap on the 3-bit instance
        repeat (6) frame(1, 1, 0, M_PASS, 1, -1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, M_NONE, 1'b0);
        chk("wrap_small_before", sm_frame_cnt, 3'd7);
        frame(1, 1, 0, M_PASS, 3, -1, 1'b0);
        chk("wrap_small_after", sm_frame_cnt, 3'd0);
        chk("wrap_wide_after", ov_frame_cnt, 16'd8);
        repeat (2) cyc(1'b0, 1'b0, M_NONE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_frame_gate.md
STREAM_FRAME_GATE -- requirements
Module: stream_frame_gate

Interface
REQ-001 Parameter SENSOR_DAT_WIDTH, default 10, bits per pixel per channel.
REQ-002 Parameter CHANNEL_NUM, default 4, pixel channels per clock.
REQ-003 Parameter CNT_WD, default 16, width of the frame statistics counters.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk_pix  input  1  pixel clock; all logic on its rising edge.
REQ-006 reset_pix  input  1  synchronous, active-high reset.
REQ-007 i_fval  input  1  frame valid from the sync buffer.
REQ-008 i_lval  input  1  line valid from the sync buffer.
REQ-009 iv_pix_data  input  SENSOR_DAT_WIDTH*CHANNEL_NUM  pixel data from the sync buffer.
REQ-010 i_stream_enable  input  1  stream enable (SE), asynchronous to frame timing but already in the clk_pix domain.
REQ-011 i_acquisition_start  input  1  acquisition start.
REQ-012 i_encrypt_state  input  1  encryption check passed.
REQ-013 o_fval  output  1  gated frame valid.
REQ-014 o_lval  output  1  gated line valid.
REQ-015 ov_pix_data  output  SENSOR_DAT_WIDTH*CHANNEL_NUM  gated pixel data.
REQ-016 o_frame_done  output  1  one-cycle pulse at the end of each passed frame.
REQ-017 ov_frame_cnt  output  CNT_WD  count of passed frames.
REQ-018 ov_drop_cnt  output  CNT_WD  count of dropped frames.

Function
REQ-019 Enable SHALL be the AND of i_stream_enable, i_acquisition_start and i_encrypt_state, sampled in the same cycle as the i_fval rising edge.
REQ-020 Rising edge: i_fval=1 this cycle and 0 the previous cycle. Falling edge: i_fval=0 this cycle and 1 the previous cycle.
REQ-021 FSM states SHALL be IDLE, PASS and DROP.
REQ-022 IDLE transitions on a rising edge: to PASS if enable=1, to DROP if enable=0.
REQ-023 PASS and DROP SHALL each return to IDLE on a falling edge.
REQ-024 Enable changes while in PASS or DROP SHALL be ignored; frames are never truncated or partially passed.
REQ-025 Each output SHALL equal its input delayed by exactly 2 clk_pix cycles, masked as follows:
  - o_fval high only for cycles belonging to a PASS frame.
  - o_lval = delayed i_lval AND o_fval.
  - ov_pix_data = delayed data when o_lval=1, else all zeros.
REQ-026 The first cycle of a frame (the rising-edge cycle) SHALL be included in the output frame when the frame enters PASS.
REQ-027 On a falling edge out of PASS:
  - o_frame_done pulses high for 1 cycle, aligned with the first cycle in which o_fval is low.
  - ov_frame_cnt increments by 1.
REQ-028 On a falling edge out of DROP, ov_drop_cnt SHALL increment by 1, and o_frame_done SHALL stay low.
REQ-029 Both counters SHALL wrap from 2^CNT_WD-1 to 0 without flagging.
REQ-030 i_lval high while i_fval is low SHALL never appear on o_lval.
REQ-031 Minimum frame size:
  - A frame with i_fval high for 1 cycle SHALL be handled like any other frame: passed or dropped, and counted.
  - Back-to-back frames with a single low i_fval cycle between them SHALL be detected as separate frames.
REQ-032 Enable rising in the same cycle as the i_fval rising edge SHALL pass the frame; enable falling in that cycle SHALL drop it.

Reset
REQ-033 While reset_pix=1, the following SHALL be 0 on the next clock edge:
  - o_fval, o_lval, ov_pix_data, o_frame_done
  - ov_frame_cnt, ov_drop_cnt
  - all pipeline registers, except the previous-i_fval register
  The FSM SHALL go to IDLE.
REQ-034 The previous-i_fval register SHALL reset to 1, so that an i_fval already high at reset release is not seen as a rising edge.
REQ-035 A frame in progress at reset release SHALL produce no output and no count.
REQ-036 Normal operation SHALL begin with the first full rising edge after reset release.
REQ-037 A reset asserted mid-frame SHALL force all outputs low on the next edge, and the rest of that frame SHALL be suppressed.

Verification
REQ-038 Basic pass: all enables = 1, 3 frames of 64 lines x 64 clocks -> o_* equals input delayed by 2 cycles; ov_frame_cnt=3; three o_frame_done pulses; ov_drop_cnt=0.
REQ-039 SE toggled in the middle of frame blanking (random 50-150 clocks) for 30 frames -> only frames starting with SE=1 appear; each is complete; ov_frame_cnt + ov_drop_cnt = 30.
REQ-040 SE dropped mid-frame, then raised mid-frame -> the first frame is output complete; the next frame is dropped entirely; the frame after that passes.
REQ-041 Minimum-size frames: i_fval high 1, 2 and 3 cycles with 1-cycle gaps -> 3 separate frames, each with a matching o_fval width and one o_frame_done each.
REQ-042 Reset released with i_fval high -> that frame is suppressed with no count change; the next frame passes; ov_frame_cnt=1.
REQ-043 Counter wrap: ov_frame_cnt forced to 0xFFFF with CNT_WD=16, then one passed frame -> ov_frame_cnt=0x0000.
